spi_master_engine: RTL

SPI_MASTER_ENGINE -- requirements
Module: spi_master_engine

---
 rtl/spi_master_engine.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/spi_master_engine.sv
// SPI mode-0 master: one byte per txgo/txrdy handshake, MSB first, optional held frames.
// Optional feature macro SPI_RX_FIFO_EN adds a 4-entry receive FIFO with an rxpop port.
module spi_master_engine #(
  parameter int CLK_DIV = 4
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic [7:0] txdin,
  input  logic       txgo,
  output logic       txrdy,
  input  logic       hold,
  output logic [7:0] rxdout,
  output logic       rxvalid,
`ifdef SPI_RX_FIFO_EN
  input  logic       rxpop,
`endif
  input  logic       MISO,
  output logic       MOSI,
  output logic       SCLK,
  output logic       SSn,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state;
  logic [7:0] div_cnt;
  logic [3:0] half_cnt;
  logic [7:0] tx_sr;
  logic [7:0] rx_sr;
  logic [7:0] rx_byte;
  logic       rx_load;
  logic       sclk_q;
  logic       ssn_q;
  logic       mosi_q;
  logic       txrdy_q;
  logic       div_end;

  assign div_end   = (div_cnt == DIV_LAST);
  assign SCLK      = sclk_q;
  assign SSn       = ssn_q;
  assign MOSI      = mosi_q;
  assign txrdy     = txrdy_q;
  assign dbg_state = state;

  // Handshake: a byte is accepted on any rising edge where txgo=1 and txrdy=1;
  // txgo while txrdy=0 is dropped, nothing is queued.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= IDLE;
      div_cnt  <= 8'd0;
      half_cnt <= 4'd0;
      tx_sr    <= 8'd0;
      rx_sr    <= 8'd0;
      rx_byte  <= 8'd0;
      rx_load  <= 1'b0;
      sclk_q   <= 1'b0;
      ssn_q    <= 1'b1;
      mosi_q   <= 1'b1;
      txrdy_q  <= 1'b1;
    end else begin
      rx_load <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt <= 8'd0;
          if (txgo) begin
            tx_sr    <= txdin;
            mosi_q   <= txdin[7];
            ssn_q    <= 1'b0;
            txrdy_q  <= 1'b0;
            half_cnt <= 4'd0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (div_end) begin
            div_cnt <= 8'd0;
            sclk_q  <= 1'b1;
            rx_sr   <= {rx_sr[6:0], MISO};
            state   <= SHIFT;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        SHIFT: begin
          if (div_end) begin
            div_cnt <= 8'd0;
            if (half_cnt == 4'd15) begin
              half_cnt <= 4'd0;
              rx_byte  <= rx_sr;
              rx_load  <= 1'b1;
              state    <= HOLD;
            end else begin
              half_cnt <= half_cnt + 4'd1;
              // Even half-periods have SCLK high: their end is a falling edge.
              if (!half_cnt[0]) begin
                sclk_q <= 1'b0;
                tx_sr  <= {tx_sr[6:0], 1'b0};
                mosi_q <= tx_sr[6];
              end else begin
                sclk_q <= 1'b1;
                rx_sr  <= {rx_sr[6:0], MISO};
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (div_end) begin
            div_cnt <= 8'd0;
            if (hold) begin
              txrdy_q <= 1'b1;
              state   <= IDLE;
            end else begin
              ssn_q  <= 1'b1;
              mosi_q <= 1'b1;
              state  <= GAP;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        GAP: begin
          if (div_end) begin
            div_cnt <= 8'd0;
            txrdy_q <= 1'b1;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_RX_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] fifo_cnt;
  logic       push;
  logic       pop;

  // A byte arriving while full is dropped even if a pop happens the same cycle.
  assign push = rx_load && (fifo_cnt != 3'd4);
  assign pop  = rxpop && (fifo_cnt != 3'd0);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < 4; i++) fifo_mem[i] <= 8'd0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      fifo_cnt <= 3'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= rx_byte;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      fifo_cnt <= fifo_cnt + {2'b00, push} - {2'b00, pop};
    end
  end

  assign rxdout  = fifo_mem[rd_ptr];
  assign rxvalid = (fifo_cnt != 3'd0);
`else
  assign rxdout  = rx_byte;
  assign rxvalid = rx_load;
`endif

endmodule
